// File: rtl/memory_tile_pkg.sv
// memory_tile_pkg: shared mode encoding and level helpers for the memory tile
package memory_tile_pkg;
  typedef logic mode_t;
  localparam mode_t MODE_RAM  = 1'b0;
  localparam mode_t MODE_FIFO = 1'b1;
  function automatic int default_af(input int aw);
    return (1 << aw) - 4;
  endfunction
endpackage

// File: rtl/memory_tile_dp_ram.sv
// memory_tile_dp_ram: simple dual-port array, synchronous write, read-first registered read
module memory_tile_dp_ram
  import memory_tile_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [2**ADDR_W];
  // array write; the array itself is never reset
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  // enable-gated read register; same-edge write is not visible, giving read-first
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rdata <= '0;
    else if (re) rdata <= mem[raddr];
endmodule

// File: rtl/memory_tile_dp_fifo.sv
// memory_tile_dp_fifo: dual-port memory tile configurable as RAM or synchronous FIFO
module memory_tile_dp_fifo
  import memory_tile_pkg::*;
#(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 8,
  parameter int AF_LEVEL = default_af(ADDR_W),
  parameter int AE_LEVEL = 4
) (
  input  logic              memory_clk,
  input  logic              memory_rst_n,
  input  logic              memory_mode,
  input  logic [ADDR_W-1:0] memory_waddr,
  input  logic [ADDR_W-1:0] memory_raddr,
  input  logic [DATA_W-1:0] memory_data_in,
  input  logic              memory_wen,
  input  logic              memory_ren,
  output logic [DATA_W-1:0] memory_data_out,
  output logic              memory_full,
  output logic              memory_empty,
  output logic              memory_almost_full,
  output logic              memory_almost_empty,
  output logic              memory_overflow,
  output logic              memory_underflow,
  output logic [ADDR_W:0]   memory_count
);
  localparam int CW = ADDR_W + 1;
  localparam logic [ADDR_W:0] DEPTH = CW'(2**ADDR_W);
  localparam logic [ADDR_W:0] AF_L  = CW'(AF_LEVEL);
  localparam logic [ADDR_W:0] AE_L  = CW'(AE_LEVEL);
  mode_t           mode_q;
  logic [ADDR_W:0] wptr, rptr, count, count_nxt;
  logic            full_r, empty_r, af_r, ae_r;
  logic            chg, fifo, push_ok, pop_ok, ram_we, ram_re;
  logic [ADDR_W-1:0] ram_waddr, ram_raddr;
  // FIFO flags are kept as raw occupancy flags and masked by the mode bit, so in
  // RAM mode full/empty read 0 and at reset empty tracks the configured mode
  assign chg      = memory_mode != mode_q;
  assign fifo     = (memory_mode == MODE_FIFO) & ~chg;
  assign push_ok  = fifo & memory_wen & ~full_r;
  assign pop_ok   = fifo & memory_ren & ~empty_r;
  assign ram_we   = fifo ? push_ok : ~chg & memory_wen;
  assign ram_re   = fifo ? pop_ok : ~chg & memory_ren;
  assign ram_waddr = fifo ? wptr[ADDR_W-1:0] : memory_waddr;
  assign ram_raddr = fifo ? rptr[ADDR_W-1:0] : memory_raddr;
  assign count_nxt = chg ? '0 : count + CW'(push_ok) - CW'(pop_ok);
  assign memory_full         = full_r & memory_mode;
  assign memory_empty        = empty_r & memory_mode;
  assign memory_almost_full  = af_r & memory_mode;
  assign memory_almost_empty = ae_r & memory_mode;
  assign memory_count        = count;
  memory_tile_dp_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ram (
    .clk   (memory_clk),
    .rst_n (memory_rst_n),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (memory_data_in),
    .re    (ram_re),
    .raddr (ram_raddr),
    .rdata (memory_data_out)
  );
  // pointers, occupancy, registered flags and sticky errors; a mode change clears them all
  always_ff @(posedge memory_clk or negedge memory_rst_n)
    if (!memory_rst_n) begin
      mode_q           <= MODE_RAM;
      wptr             <= '0;
      rptr             <= '0;
      count            <= '0;
      full_r           <= 1'b0;
      empty_r          <= 1'b1;
      af_r             <= 1'b0;
      ae_r             <= 1'b1;
      memory_overflow  <= 1'b0;
      memory_underflow <= 1'b0;
    end else begin
      mode_q           <= memory_mode;
      wptr             <= chg ? '0 : wptr + CW'(push_ok);
      rptr             <= chg ? '0 : rptr + CW'(pop_ok);
      count            <= count_nxt;
      full_r           <= count_nxt == DEPTH;
      empty_r          <= count_nxt == '0;
      af_r             <= count_nxt >= AF_L;
      ae_r             <= count_nxt <= AE_L;
      memory_overflow  <= chg ? 1'b0 : memory_overflow | (fifo & memory_wen & full_r);
      memory_underflow <= chg ? 1'b0 : memory_underflow | (fifo & memory_ren & empty_r);
    end
endmodule

// File: tb/tb_memory_tile_dp_fifo.sv
// tb_memory_tile_dp_fifo: directed self-checking bench for the RAM and FIFO modes
module tb_memory_tile_dp_fifo;
  logic       clk = 1'b0;
  logic       rst_n, mode, wen, ren;
  logic [3:0] waddr, raddr;
  logic [7:0] din, dout;
  logic       full, empty, af, ae, ovf, udf;
  logic [4:0] count;
  int         n_cmp = 0;
  int         n_err = 0;

  memory_tile_dp_fifo #(.ADDR_W(4), .DATA_W(8)) dut (
    .memory_clk          (clk),
    .memory_rst_n        (rst_n),
    .memory_mode         (mode),
    .memory_waddr        (waddr),
    .memory_raddr        (raddr),
    .memory_data_in      (din),
    .memory_wen          (wen),
    .memory_ren          (ren),
    .memory_data_out     (dout),
    .memory_full         (full),
    .memory_empty        (empty),
    .memory_almost_full  (af),
    .memory_almost_empty (ae),
    .memory_overflow     (ovf),
    .memory_underflow    (udf),
    .memory_count        (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; mode = 1'b0; wen = 1'b0; ren = 1'b0;
    waddr = '0; raddr = '0; din = '0;
    #22;
    chk("rst_dout", 32'(dout), 0);
    chk("rst_empty", 32'(empty), 0);
    chk("rst_full", 32'(full), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_ovf", 32'(ovf), 0);
    rst_n = 1'b1;
    step();
    wen = 1'b1; waddr = 4'd3; din = 8'hA5;
    step();
    wen = 1'b0; ren = 1'b1; raddr = 4'd3;
    step();
    chk("ram_rd3", 32'(dout), 32'hA5);
    ren = 1'b0; wen = 1'b1; waddr = 4'd7; din = 8'h11;
    step();
    din = 8'h22; ren = 1'b1; raddr = 4'd7;
    step();
    chk("ram_rdfirst", 32'(dout), 32'h11);
    wen = 1'b0;
    step();
    chk("ram_rdnew", 32'(dout), 32'h22);
    ren = 1'b0;
    step();
    chk("ram_hold", 32'(dout), 32'h22);
    mode = 1'b1;
    step();
    chk("fifo_empty0", 32'(empty), 1);
    chk("fifo_count0", 32'(count), 0);
    for (int i = 0; i < 16; i++) begin
      wen = 1'b1; din = 8'(i);
      step();
      chk("push_count", 32'(count), 32'(i + 1));
      chk("push_ae", 32'(ae), 32'(i + 1 <= 4));
      chk("push_af", 32'(af), 32'(i + 1 >= 12));
    end
    chk("full16", 32'(full), 1);
    chk("ovf_before", 32'(ovf), 0);
    din = 8'h99;
    step();
    chk("ovf_set", 32'(ovf), 1);
    chk("ovf_count", 32'(count), 16);
    ren = 1'b1; din = 8'h77;
    step();
    chk("pp_full_dout", 32'(dout), 0);
    chk("pp_full_count", 32'(count), 15);
    chk("pp_full_ovf", 32'(ovf), 1);
    wen = 1'b0;
    for (int i = 1; i < 16; i++) begin
      step();
      chk("pop_data", 32'(dout), 32'(i));
    end
    chk("drained_empty", 32'(empty), 1);
    chk("drained_count", 32'(count), 0);
    step();
    chk("udf_set", 32'(udf), 1);
    chk("udf_dout", 32'(dout), 15);
    chk("udf_count", 32'(count), 0);
    ren = 1'b0; mode = 1'b0;
    step();
    mode = 1'b1;
    step();
    chk("toggle_udf", 32'(udf), 0);
    chk("toggle_ovf", 32'(ovf), 0);
    chk("toggle_empty", 32'(empty), 1);
    for (int k = 0; k < 40; k++) begin
      wen = 1'b1; din = 8'(8'h40 + k); ren = k > 0;
      step();
      if (k > 0) chk("wrap_data", 32'(dout), 32'(8'h40 + k - 1));
      chk("wrap_count", 32'(count), 1);
    end
    ren = 1'b0;
    step();
    step();
    chk("pre_rst_count", 32'(count), 3);
    #2 rst_n = 1'b0;
    #1;
    chk("async_count", 32'(count), 0);
    chk("async_empty", 32'(empty), 1);
    chk("async_dout", 32'(dout), 0);
    wen = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
